// File: rtl/sd_card_cmd_responder.sv
// sd_card_cmd_responder: card-side SD CMD line endpoint (command receive, CRC7 check, R1/R2/R3 response)
module sd_card_cmd_responder #(
    parameter int NcrCycles  = 2,
    parameter int RspTimeout = 64
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         cmd_i,
    output logic         cmd_o,
    output logic         cmd_en_o,
    output logic         cmd_valid_o,
    output logic [5:0]   cmd_index_o,
    output logic [31:0]  cmd_arg_o,
    output logic         cmd_err_o,
    input  logic         rsp_valid_i,
    output logic         rsp_ready_o,
    input  logic [1:0]   rsp_type_i,
    input  logic [5:0]   rsp_index_i,
    input  logic [119:0] rsp_payload_i,
    output logic         rsp_timeout_o,
    output logic         busy_o
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RECV  = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_NCR   = 3'd4;
    localparam logic [2:0] S_SEND  = 3'd5;
    localparam int TW = $clog2(RspTimeout + 1);

    logic [2:0]   state, state_d;
    logic [7:0]   bit_cnt;
    logic [TW-1:0] tmr;
    logic [45:0]  rx_sr;
    logic [6:0]   rx_crc;
    logic         cmd_ok;
    logic [135:0] tx_sr, tx_load;
    logic         tx_long;
    logic [39:0]  r1_head;
    logic         rx_end, frame_ok, hs, gap_done, time_out, tx_last;

    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        return {c[5:0], 1'b0} ^ ((c[6] ^ b) ? 7'h09 : 7'h00);
    endfunction

    function automatic logic [6:0] crc7_vec(input logic [119:0] d, input int n);
        logic [6:0] c = 7'h00;
        for (int i = 119; i >= 0; i--)
            if (i < n) c = crc7_step(c, d[i]);
        return c;
    endfunction

    assign rx_end   = state == S_RECV && bit_cnt == 8'd47;
    assign frame_ok = rx_sr[45] && rx_crc == rx_sr[6:0] && cmd_i;
    assign hs       = state == S_WAIT && rsp_valid_i;
    assign gap_done = tmr >= TW'(NcrCycles - 1);
    assign time_out = tmr == TW'(RspTimeout - 1);
    assign tx_last  = bit_cnt == (tx_long ? 8'd135 : 8'd47);
    assign r1_head  = {2'b00, rsp_index_i, rsp_payload_i[31:0]};
    assign tx_load  = (rsp_type_i == 2'd2) ? {8'h3F, rsp_payload_i, crc7_vec(rsp_payload_i, 120), 1'b1} :
                      (rsp_type_i == 2'd1) ? {r1_head, crc7_vec({80'b0, r1_head}, 40), 1'b1, 88'b0} :
                                             {8'h3F, rsp_payload_i[31:0], 7'h7F, 1'b1, 88'b0};

    assign cmd_en_o    = state == S_SEND;
    assign cmd_o       = cmd_en_o ? tx_sr[135] : 1'b1;
    assign rsp_ready_o = state == S_WAIT;
    assign busy_o      = state != S_IDLE;

    // next-state selection; a handshake takes priority over the response timeout
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  state_d = cmd_i ? S_IDLE : S_RECV;
            S_RECV:  state_d = rx_end ? S_CHECK : S_RECV;
            S_CHECK: state_d = cmd_ok ? S_WAIT : S_IDLE;
            S_WAIT:  state_d = hs ? (rsp_type_i == 2'd0 ? S_IDLE : gap_done ? S_SEND : S_NCR) :
                               time_out ? S_IDLE : S_WAIT;
            S_NCR:   state_d = gap_done ? S_SEND : S_NCR;
            S_SEND:  state_d = tx_last ? S_IDLE : S_SEND;
            default: state_d = S_IDLE;
        endcase
    end

    // state register and the bit / gap counters; the gap timer restarts at the command end bit
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= S_IDLE;
            bit_cnt <= 8'd0;
            tmr     <= '0;
        end else begin
            state   <= state_d;
            bit_cnt <= (state == S_IDLE) ? 8'd1 :
                       (state == S_RECV || state == S_SEND) ? bit_cnt + 8'd1 : 8'd0;
            tmr     <= rx_end ? '0 : tmr + 1'b1;
        end
    end

    // command deserialiser: the CRC runs over the start bit through the argument
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_sr  <= '0;
            rx_crc <= 7'h00;
        end else if (state == S_IDLE) begin
            rx_crc <= crc7_step(7'h00, cmd_i);
        end else if (state == S_RECV && !rx_end) begin
            rx_sr  <= {rx_sr[44:0], cmd_i};
            rx_crc <= (bit_cnt <= 8'd39) ? crc7_step(rx_crc, cmd_i) : rx_crc;
        end
    end

    // frame verdict pulses and the held command fields, registered as the end bit arrives
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cmd_valid_o   <= 1'b0;
            cmd_err_o     <= 1'b0;
            cmd_ok        <= 1'b0;
            rsp_timeout_o <= 1'b0;
            cmd_index_o   <= 6'd0;
            cmd_arg_o     <= 32'd0;
        end else begin
            cmd_valid_o   <= rx_end && frame_ok;
            cmd_err_o     <= rx_end && !frame_ok;
            cmd_ok        <= rx_end ? frame_ok : cmd_ok;
            rsp_timeout_o <= state == S_WAIT && !hs && time_out;
            if (rx_end && frame_ok) begin
                cmd_index_o <= rx_sr[44:39];
                cmd_arg_o   <= rx_sr[38:7];
            end
        end
    end

    // response serialiser: frame is built MSB-aligned at the handshake and shifted out while sending
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_sr   <= '0;
            tx_long <= 1'b0;
        end else if (hs) begin
            tx_sr   <= tx_load;
            tx_long <= rsp_type_i == 2'd2;
        end else if (state == S_SEND) begin
            tx_sr   <= {tx_sr[134:0], 1'b0};
        end
    end
endmodule

// File: doc/sd_card_cmd_responder.md
# sd_card_cmd_responder

Card-side endpoint of the SD CMD line: the responder to the host command path in `cmd_wrap`. It deserialises 48-bit host commands, checks framing and CRC7, and presents index and argument to card logic. It then serialises the R1/R2/R3 response returned by that logic after the Ncr gap. It is used by the synthesizable SD card model and by the card-emulation FPGA bench. It runs directly on the SD bus clock.

## Interface
- `NcrCycles`, default 2: cycles from command end bit to response start bit. Legal range 2..64.
- `RspTimeout`, default 64: cycles after the end bit before an unanswered command is dropped. Must be greater than `NcrCycles`.
- `clk_i` in 1: SD bus clock. Host drives CMD and samples CMD on the rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `cmd_i` in 1: sampled CMD line.
- `cmd_o` out 1: CMD value driven by the card.
- `cmd_en_o` out 1: CMD output enable.
- `cmd_valid_o` out 1: one-cycle pulse; a good command is on `cmd_index_o`/`cmd_arg_o`.
- `cmd_index_o` out 6: received command index. Held until the next good command.
- `cmd_arg_o` out 32: received argument. Held until the next good command.
- `cmd_err_o` out 1: one-cycle pulse on a bad frame (transmission bit, CRC or end bit).
- `rsp_valid_i` in 1: response offer from card logic.
- `rsp_ready_o` out 1: response accepted when `rsp_valid_i && rsp_ready_o`.
- `rsp_type_i` in 2: response type. 0 = none, 1 = R1 (48-bit, CRC), 2 = R2 (136-bit), 3 = R3 (48-bit, no CRC).
- `rsp_index_i` in 6: index field for R1.
- `rsp_payload_i` in 120: R1/R3 use bits [31:0]; R2 uses all 120 bits.
- `rsp_timeout_o` out 1: one-cycle pulse when `RspTimeout` expires.
- `busy_o` out 1: high in every state except IDLE.

## Operation
- **States:** IDLE, RECV, CHECK, WAIT_RSP, NCR, SEND.
- **IDLE:** `cmd_i == 0` sampled → RECV. The bit counter is set to 1, and the start bit is included in the CRC.
- **RECV:** shifts bits 1..47 MSB first.
  - Bit 1 is the transmission bit and must be 1.
  - Bits 2–7 are the index, bits 8–39 the argument, bits 40–46 the CRC7, bit 47 the end bit.
  - After bit 47 → CHECK.
- **CRC7:** polynomial x^7+x^3+1, initial value 0, computed serially over bits 0–39. It is compared against bits 40–46.
- **CHECK** (one cycle):
  - Good frame: pulse `cmd_valid_o`, update `cmd_index_o`/`cmd_arg_o` → WAIT_RSP.
  - Bad frame: pulse `cmd_err_o`, outputs unchanged → IDLE (no response).
- **WAIT_RSP:** `rsp_ready_o = 1`. On handshake, latch type, index and payload.
  - Type 0 → IDLE.
  - Otherwise → NCR if the gap has not elapsed, else → SEND.
  - If `RspTimeout` cycles pass since the end bit with no handshake: pulse `rsp_timeout_o` → IDLE.
- **NCR:** counts until the gap expires → SEND.
- **SEND frames** (MSB first, `cmd_en_o = 1` for the whole frame):
  - R1: 0, 0, index[5:0], payload[31:0], CRC7 over the first 40 bits, 1 (48 bits).
  - R3: 0, 0, 6'h3F, payload[31:0], 7'h7F, 1 (48 bits).
  - R2: 0, 0, 6'h3F, payload[119:0], CRC7 over the 120 payload bits, 1 (136 bits).
- **After the end bit:** `cmd_en_o` = 0, `cmd_o` = 1 → IDLE.
- **When not driving:** `cmd_o` = 1. `cmd_i` is ignored outside IDLE and RECV.
- **Counters:** 8-bit bit counter; gap/timeout counter wide enough for `RspTimeout`.

## Timing
- **Reset values** (applied asynchronously, released by the first edge after deassert):
  - `cmd_en_o` = 0, `cmd_o` = 1.
  - `cmd_valid_o`, `cmd_err_o`, `rsp_ready_o`, `rsp_timeout_o`, `busy_o` = 0.
  - `cmd_index_o` = 0, `cmd_arg_o` = 0.
  - State = IDLE.
- **Reset mid-frame:** the line is released immediately and the partial frame is discarded.
- **Command latency:** end bit sampled at edge k → `cmd_valid_o`/`cmd_err_o` high for cycle k+1 only. `rsp_ready_o` rises at k+2.
- **Response start:** start bit driven from edge k+`NcrCycles`, provided the handshake completed by edge k+`NcrCycles`−1. Otherwise it is driven on the edge after the handshake.
- **Handshake at edge k+1** (CHECK cycle): ignored, because `rsp_ready_o` is still 0.
- **Handshake and timeout in the same cycle:** the handshake wins.
- **Back-to-back:** a new start bit is accepted on the first edge after returning to IDLE.
- **Frame length:** R1/R3 occupy exactly 48 driven cycles; R2 exactly 136.

## Test plan
- **CMD0, good frame.** Send 0x40_00000000 with CRC byte 0x95. Expect `cmd_valid_o` one cycle after the end bit, index 0, arg 0. Then offer type 0: no drive, `busy_o` drops.
- **CMD8, bad CRC.** Send 0x48_000001AA with CRC byte 0x87: good, index 8, arg 0x000001AA. Resend with CRC byte 0x86: `cmd_err_o` pulse, `rsp_ready_o` stays 0, line never driven.
- **R3 response.** After a good command, offer R3 with payload 0x80FF8000 at the earliest cycle. Expect the bitstream 0x3F_80FF8000_FF, start bit exactly `NcrCycles` after the end bit, `cmd_en_o` high for 48 cycles.
- **R1 and R2 CRC.** R1 with index 17 and payload 0x00000900; R2 with a random 120-bit payload. Check the CRC7 against the bench reference model and check frame lengths of 48 and 136.
- **Late response and timeout.** Offer R1 10 cycles after the end bit: start bit on the next edge. Never offer: `rsp_timeout_o` at cycle `RspTimeout`, then a following CMD0 is accepted.
- **Reset during SEND.** Assert `rst_ni` low mid-R2: `cmd_en_o` drops without waiting for a clock, and all outputs go to their reset values.
